// File: rtl/sprite_hit_pipe.sv
// Two-stage pixel-vs-sprite rectangle hit pipeline with valid/ready handshake
// and sticky per-frame collision flags for sprites overlapping on one pixel.
module sprite_hit_pipe #(
    parameter int  NUM_SPRITES = 4,
    parameter int  COORD_W     = 16,
    localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int SPR_W       = 4 * COORD_W
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_SPRITES*SPR_W-1:0] sprites_in,
    input  logic [NUM_SPRITES-1:0]       sprite_en,
    input  logic                         frame_start,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [COORD_W-1:0]           pix_x,
    input  logic [COORD_W-1:0]           pix_y,
    output logic                         hit_valid,
    input  logic                         hit_ready,
    output logic [NUM_SPRITES-1:0]       hit_vec,
    output logic                         hit_any,
    output logic [IDX_W-1:0]             hit_idx,
    output logic [NUM_SPRITES-1:0]       collide_flags,
    output logic                         collide_any
);

    logic                         advance;
    logic                         transfer;
    logic                         multi_hit;

    logic                         s1_valid_q;
    logic [COORD_W-1:0]           s1_x_q;
    logic [COORD_W-1:0]           s1_y_q;
    logic [NUM_SPRITES*SPR_W-1:0] s1_spr_q;
    logic [NUM_SPRITES-1:0]       s1_en_q;

    logic                         hit_valid_q;
    logic [NUM_SPRITES-1:0]       hit_vec_q;
    logic [NUM_SPRITES-1:0]       hit_vec_d;
    logic                         hit_any_q;
    logic [IDX_W-1:0]             hit_idx_q;
    logic [IDX_W-1:0]             hit_idx_d;

    logic [NUM_SPRITES-1:0]       collide_q;
    logic [NUM_SPRITES-1:0]       collide_d;

    // Both stages move together; a held result freezes the whole pipe.
    assign advance   = !hit_valid_q || hit_ready;
    assign pix_ready = advance;
    assign transfer  = hit_valid_q && hit_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_spr_q   <= '0;
            s1_en_q    <= '0;
        end else if (advance) begin
            s1_valid_q <= pix_valid;
            if (pix_valid) begin
                s1_x_q   <= pix_x;
                s1_y_q   <= pix_y;
                s1_spr_q <= sprites_in;
                s1_en_q  <= sprite_en;
            end
        end
    end

    // Far edges use one extra bit so rectangles past the top coordinate clamp, not wrap.
    always_comb begin
        logic [COORD_W-1:0] sx, sy, sw, sh;
        logic [COORD_W:0]   x_end, y_end;
        logic               in_x, in_y;
        hit_vec_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sx    = s1_spr_q[SPR_W*i + 3*COORD_W +: COORD_W];
            sy    = s1_spr_q[SPR_W*i + 2*COORD_W +: COORD_W];
            sw    = s1_spr_q[SPR_W*i + 1*COORD_W +: COORD_W];
            sh    = s1_spr_q[SPR_W*i +: COORD_W];
            x_end = {1'b0, sx} + {1'b0, sw};
            y_end = {1'b0, sy} + {1'b0, sh};
            in_x  = (s1_x_q >= sx) && ({1'b0, s1_x_q} < x_end);
            in_y  = (s1_y_q >= sy) && ({1'b0, s1_y_q} < y_end);
            hit_vec_d[i] = s1_valid_q && s1_en_q[i] && in_x && in_y;
        end
    end

    always_comb begin
        hit_idx_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec_d[i]) begin
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_valid_q <= 1'b0;
            hit_vec_q   <= '0;
            hit_any_q   <= 1'b0;
            hit_idx_q   <= '0;
        end else if (advance) begin
            hit_valid_q <= s1_valid_q;
            hit_vec_q   <= hit_vec_d;
            hit_any_q   <= |hit_vec_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi_hit = |(hit_vec_q & (hit_vec_q - 1'b1));

    always_comb begin
        collide_d = collide_q;
        if (frame_start) begin
            collide_d = '0;
        end
        if (transfer && multi_hit) begin
            collide_d = collide_d | hit_vec_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            collide_q <= '0;
        end else begin
            collide_q <= collide_d;
        end
    end

    assign hit_valid     = hit_valid_q;
    assign hit_vec       = hit_vec_q;
    assign hit_any       = hit_any_q;
    assign hit_idx       = hit_idx_q;
    assign collide_flags = collide_q;
    assign collide_any   = |collide_q;

endmodule

// File: tb/tb_sprite_hit_pipe.sv
// Directed bench for sprite_hit_pipe: latency, hit geometry, priority index,
// stalls, collision flags with frame_start, and mid-flight reset.
module tb_sprite_hit_pipe;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            resetn;
    logic [N*64-1:0] sprites_in;
    logic [N-1:0]    sprite_en;
    logic            frame_start;
    logic            pix_valid;
    logic            pix_ready;
    logic [CW-1:0]   pix_x;
    logic [CW-1:0]   pix_y;
    logic            hit_valid;
    logic            hit_ready;
    logic [N-1:0]    hit_vec;
    logic            hit_any;
    logic [IW-1:0]   hit_idx;
    logic [N-1:0]    collide_flags;
    logic            collide_any;

    logic [63:0]     spr_q [N];
    int              checks   = 0;
    int              failures = 0;

    always #5 clock = ~clock;

    always_comb sprites_in = {spr_q[3], spr_q[2], spr_q[1], spr_q[0]};

    sprite_hit_pipe #(.NUM_SPRITES(N), .COORD_W(CW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .sprites_in    (sprites_in),
        .sprite_en     (sprite_en),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit_vec       (hit_vec),
        .hit_any       (hit_any),
        .hit_idx       (hit_idx),
        .collide_flags (collide_flags),
        .collide_any   (collide_any)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] spr(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] w, input logic [15:0] h);
        return {x, y, w, h};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        pix_x     = x;
        pix_y     = y;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
    endtask

    task automatic load_default();
        spr_q[0] = spr(200, 200, 100, 100);
        spr_q[1] = spr(400, 200, 50, 100);
        spr_q[2] = spr(200, 400, 400, 30);
        spr_q[3] = spr(250, 250, 100, 100);
    endtask

    logic [15:0] sx [8] = '{16'd210, 16'd260, 16'd420, 16'd300, 16'd320, 16'd10, 16'd299, 16'd300};
    logic [15:0] sy [8] = '{16'd270, 16'd260, 16'd250, 16'd410, 16'd320, 16'd10, 16'd299, 16'd300};
    logic [3:0]  ev [8] = '{4'b0001, 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1001, 4'b1000};

    initial begin
        int sent;
        int rcv;
        bit stall_seen;
        load_default();
        sprite_en   = 4'b1111;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        hit_ready   = 1'b1;
        resetn      = 1'b0;
        #12;
        check("rst_valid", hit_valid, 0);
        check("rst_ready", pix_ready, 1);
        check("rst_flags", collide_flags, 0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // single pixel latency
        send(210, 270);
        check("lat_early", hit_valid, 0);
        step();
        check("p1_valid", hit_valid, 1);
        check("p1_vec", hit_vec, 4'b0001);
        check("p1_idx", hit_idx, 0);
        check("p1_any", hit_any, 1);
        check("p1_flags", collide_flags, 0);
        step();
        check("bubble_valid", hit_valid, 0);
        check("bubble_vec", hit_vec, 0);

        // back-to-back misses then an overlap pixel
        pix_valid = 1'b1; pix_x = 350; pix_y = 130;
        step();
        pix_x = 210; pix_y = 70;
        step();
        check("miss1_valid", hit_valid, 1);
        check("miss1_vec", hit_vec, 0);
        check("miss1_any", hit_any, 0);
        pix_x = 260; pix_y = 260;
        step();
        check("miss2_valid", hit_valid, 1);
        check("miss2_vec", hit_vec, 0);
        pix_valid = 1'b0;
        step();
        check("ovl_vec", hit_vec, 4'b1001);
        check("ovl_idx", hit_idx, 0);
        check("ovl_flags_pre", collide_flags, 0);
        step();
        check("ovl_flags", collide_flags, 4'b1001);
        check("ovl_cany", collide_any, 1);

        // frame_start alone clears
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_clear", collide_flags, 0);
        check("fs_cany", collide_any, 0);

        // sprite1 moved onto sprite2 for one pixel, restored right after acceptance
        spr_q[1] = spr(200, 400, 50, 30);
        send(210, 410);
        load_default();
        step();
        check("snap_vec", hit_vec, 4'b0110);
        check("snap_idx", hit_idx, 1);
        step();
        check("snap_flags", collide_flags, 4'b0110);

        // frame_start coinciding with a qualifying transfer
        send(260, 260);
        step();
        check("fs_tx_vec", hit_vec, 4'b1001);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_tx_flags", collide_flags, 4'b1001);

        // zero width and far-edge clamping
        spr_q[1] = spr(400, 200, 0, 100);
        send(400, 250);
        load_default();
        step();
        check("w0_vec", hit_vec, 0);
        spr_q[2] = spr(65500, 0, 100, 10);
        send(65535, 5);
        load_default();
        step();
        check("edge_vec", hit_vec, 4'b0100);
        check("edge_idx", hit_idx, 2);

        // disabled sprite and highest index
        sprite_en = 4'b1110;
        send(210, 270);
        sprite_en = 4'b1111;
        step();
        check("dis_vec", hit_vec, 0);
        check("dis_idx", hit_idx, 0);
        send(320, 320);
        step();
        check("idx3_vec", hit_vec, 4'b1000);
        check("idx3_idx", hit_idx, 3);
        step();

        // stream of 8 with a 3-cycle output stall
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        sent = 0;
        rcv = 0;
        stall_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            pix_valid = (sent < 8);
            if (sent < 8) begin
                pix_x = sx[sent];
                pix_y = sy[sent];
            end
            hit_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (!hit_ready) begin
                stall_seen = 1'b1;
                check("stall_ready", pix_ready, 0);
            end
            if (hit_valid && hit_ready) begin
                check($sformatf("stream_vec%0d", rcv), hit_vec, ev[rcv]);
                rcv++;
            end
            if (pix_valid && pix_ready) sent++;
            @(posedge clock);
            #1;
        end
        pix_valid = 1'b0;
        hit_ready = 1'b1;
        check("stream_rcv", rcv, 8);
        check("stream_sent", sent, 8);
        check("stream_stalled", stall_seen, 1);
        step();
        check("stream_dup", hit_valid, 0);
        check("stream_flags", collide_flags, 4'b1001);

        // reset with two pixels in flight
        pix_valid = 1'b1; pix_x = 260; pix_y = 260;
        step();
        pix_x = 320; pix_y = 320;
        step();
        pix_valid = 1'b0;
        check("inflight_valid", hit_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_valid", hit_valid, 0);
        check("arst_vec", hit_vec, 0);
        check("arst_flags", collide_flags, 0);
        check("arst_ready", pix_ready, 1);
        @(negedge clock);
        resetn = 1'b1;
        step();
        check("post_rst1", hit_valid, 0);
        step();
        check("post_rst2", hit_valid, 0);
        send(420, 250);
        step();
        check("post_rst_vec", hit_vec, 4'b0010);
        check("post_rst_idx", hit_idx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sprite_hit_pipe.md
SPRITE_HIT_PIPE -- requirements
Module: sprite_hit_pipe

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4; number of sprite rectangles tested per pixel; range 2..16.
REQ-002 SHALL have parameter COORD_W, default 16; bit width of each coordinate and dimension field.
REQ-003 SHALL derive IDX_W = max(1, clog2(NUM_SPRITES)) and SPR_W = 4*COORD_W.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 sprites_in  in  NUM_SPRITES*SPR_W  packed rectangles. Sprite i occupies bits [SPR_W*i+SPR_W-1 : SPR_W*i], with fields {x, y, w, h}, x in the top COORD_W bits.
REQ-008 sprite_en  in  NUM_SPRITES  per-sprite enable; a disabled sprite never hits.
REQ-009 frame_start  in  1  single-cycle pulse; clears the collision accumulators.
REQ-010 pix_valid / pix_ready  in / out  1 / 1  pixel input handshake.
REQ-011 pix_x, pix_y  in  COORD_W each  pixel coordinate, in the same coordinate frame as the sprite fields.
REQ-012 hit_valid / hit_ready  out / in  1 / 1  result output handshake.
REQ-013 hit_vec  out  NUM_SPRITES  bit i set when the pixel lies inside sprite i.
REQ-014 hit_any  out  1  OR-reduction of hit_vec.
REQ-015 hit_idx  out  IDX_W  lowest set index of hit_vec (lowest index = highest priority); 0 when hit_vec is 0.
REQ-016 collide_flags  out  NUM_SPRITES  sticky per-frame overlap flags.
REQ-017 collide_any  out  1  OR-reduction of collide_flags.

Function
REQ-018 Inside test for sprite i: x <= pix_x < x+w AND y <= pix_y < y+h AND sprite_en[i].
REQ-019 x+w and y+h SHALL be computed at COORD_W+1 bits; no wrap-around; a sprite whose far edge exceeds 2^COORD_W-1 still covers up to the maximum coordinate.
REQ-020 w=0 or h=0 SHALL never hit.
REQ-021 Comparisons unsigned.
REQ-022 Pipeline has two registered stages.
- S1: on acceptance (pix_valid & pix_ready), captures pix_x, pix_y, sprites_in and sprite_en.
- S2: registers hit_vec, hit_any and hit_idx, and asserts hit_valid.
REQ-023 A pixel accepted in cycle N SHALL appear on hit_* in cycle N+2 when the pipeline is not stalled.
REQ-024 Throughput one pixel per cycle while hit_ready is held high.
REQ-025 Stall rule: advance = !hit_valid | hit_ready.
- pix_ready = advance.
- While advance=0, S1 and S2 hold their contents and hit_* SHALL stay stable.
REQ-026 Changes to sprites_in or sprite_en after acceptance SHALL NOT affect that pixel's result.
REQ-027 A pipeline bubble (S1 empty while advancing) SHALL deassert hit_valid on the next edge.
REQ-028 Transfer = hit_valid & hit_ready. On a transfer with popcount(hit_vec) >= 2, collide_flags |= hit_vec.
REQ-029 frame_start SHALL clear collide_flags.
- If it coincides with a qualifying transfer, the result is that transfer's hit_vec alone (the pixel counts toward the new frame).
REQ-030 frame_start SHALL NOT flush or stall the pipeline.
REQ-031 collide_flags SHALL update one cycle after the transfer; collide_any is combinational from collide_flags.
REQ-032 hit_vec, hit_idx and hit_any SHALL be 0 whenever hit_valid=0.

Reset
REQ-033 resetn low SHALL asynchronously clear S1/S2 valid bits, hit_valid, hit_vec, hit_idx, hit_any and collide_flags to 0.
REQ-034 During reset pix_ready SHALL be 1.
REQ-035 Reset mid-operation discards all in-flight pixels; no partial result appears after release.
REQ-036 The first acceptance is possible on the first clock edge after resetn rises.

Verification (NUM_SPRITES=4, COORD_W=16; sprite0 {200,200,100,100}, sprite1 {400,200,50,100}, sprite2 {200,400,400,30}, sprite3 {250,250,100,100}, all enabled)
REQ-037 Pixel (210,270) with hit_ready=1 -> two cycles later hit_vec=0001, hit_idx=0, hit_any=1, collide_flags=0000.
REQ-038 Pixels (350,130) then (210,70) back-to-back -> consecutive results hit_vec=0000, hit_any=0; then pixel (260,260) -> hit_vec=1001, hit_idx=0, and one cycle after transfer collide_flags=1001, collide_any=1.
REQ-039 Stream 8 pixels with hit_ready low for 3 cycles mid-stream -> pix_ready low during the stall, no result lost or duplicated, order preserved.
REQ-040 Sprite1 with w=0, pixel (400,250) -> hit_vec=0000; sprite {65500,0,100,10}, pixel (65535,5) -> that sprite's bit set.
REQ-041 frame_start asserted in the same cycle as the (260,260) transfer, flags previously 0110 -> collide_flags=1001.
REQ-042 resetn pulsed low while two pixels are in flight -> hit_valid=0 and collide_flags=0 immediately, and no stale result after release.
